phoenix_packet_tx: RTL and testbench

Link-side transmitter that drives a Phoenix router input port (rx / data_in / credit_o) from a local IP core. It accepts a packet descriptor (target, payload size) and a payload flit stream. It serialises header flit, size flit, then payload flits under credit-based flow control. It sits in the network interface on the local port, or at any router output that feeds a downstream input buffer.

---
 rtl/phoenix_packet_tx.sv | 126 ++++++++++++
 tb/tb_phoenix_packet_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_packet_tx.sv
// Phoenix link transmitter: sends header, size and payload flits to a router input under credit flow control.
// Define PHOENIX_TX_STATS_EN to add the stat_pkts / stat_flits counters.
module phoenix_packet_tx #(
  parameter int TAM_FLIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [TAM_FLIT-1:0] pkt_target,
  input  logic [TAM_FLIT-1:0] pkt_size,
  input  logic                pay_valid,
  output logic                pay_ready,
  input  logic [TAM_FLIT-1:0] pay_data,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  output logic                clock_tx,
  input  logic                credit_i,
  output logic                busy,
`ifdef PHOENIX_TX_STATS_EN
  output logic                err_zero,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_flits
`else
  output logic                err_zero
`endif
);

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t              state, state_nxt;
  logic                out_valid, out_valid_nxt;
  logic [TAM_FLIT-1:0] out_flit, out_flit_nxt;
  logic [TAM_FLIT-1:0] size_q, size_nxt;
  logic [CNT_W-1:0]    remaining, remaining_nxt;
  logic                err_nxt;
  logic                slot_free, pkt_hs, pay_hs, hdr_load;

  assign tx        = out_valid & credit_i;
  assign slot_free = !out_valid | tx;
  assign pkt_ready = (state == IDLE) & slot_free;
  assign pay_ready = (state == PAYLOAD) & slot_free & (remaining != '0);
  assign pkt_hs    = pkt_valid & pkt_ready;
  assign pay_hs    = pay_valid & pay_ready;
  assign busy      = (state != IDLE) | out_valid;
  assign data_out  = out_flit;
  assign clock_tx  = clock;
  assign hdr_load  = pkt_hs & (pkt_size != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      size_q    <= '0;
      remaining <= '0;
      err_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      out_flit  <= out_flit_nxt;
      size_q    <= size_nxt;
      remaining <= remaining_nxt;
      err_zero  <= err_nxt;
    end
  end

  // The out register drains on tx unless a new flit reloads it on the same edge.
  always_comb begin
    state_nxt     = state;
    out_valid_nxt = out_valid & ~tx;
    out_flit_nxt  = out_flit;
    size_nxt      = size_q;
    remaining_nxt = remaining;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_load) begin
          out_flit_nxt  = pkt_target;
          out_valid_nxt = 1'b1;
          size_nxt      = pkt_size;
          state_nxt     = SIZE;
        end else if (pkt_hs) begin
          err_nxt = 1'b1;
        end
      end
      SIZE: begin
        if (slot_free) begin
          out_flit_nxt  = size_q;
          out_valid_nxt = 1'b1;
          remaining_nxt = CNT_W'(size_q);
          state_nxt     = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pay_hs) begin
          out_flit_nxt  = pay_data;
          out_valid_nxt = 1'b1;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PHOENIX_TX_STATS_EN
  // hdr_in_reg marks that the out register currently holds a header flit.
  logic hdr_in_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_in_reg <= 1'b0;
      stat_pkts  <= '0;
      stat_flits <= '0;
    end else begin
      if (tx) stat_flits <= stat_flits + 16'd1;
      if (tx & hdr_in_reg) stat_pkts <= stat_pkts + 16'd1;
      if (hdr_load) hdr_in_reg <= 1'b1;
      else if (tx) hdr_in_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_phoenix_packet_tx.sv
// Bench for phoenix_packet_tx: directed cycle vectors, reset/gap sequences and a randomized stream model.
module tb_phoenix_packet_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid, pkt_ready, pay_valid, pay_ready;
  logic [7:0] pkt_target, pkt_size, pay_data, data_out;
  logic       tx, clock_tx, credit_i, busy, err_zero;
`ifdef PHOENIX_TX_STATS_EN
  logic [15:0] stat_pkts, stat_flits;
`endif

  phoenix_packet_tx #(.TAM_FLIT(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_target(pkt_target), .pkt_size(pkt_size),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .tx(tx), .data_out(data_out), .clock_tx(clock_tx), .credit_i(credit_i),
    .busy(busy),
`ifdef PHOENIX_TX_STATS_EN
    .err_zero(err_zero), .stat_pkts(stat_pkts), .stat_flits(stat_flits)
`else
    .err_zero(err_zero)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic pv; logic [7:0] tg, sz; logic yv; logic [7:0] yd; logic cr;
    logic etx, epr, eyr, ebz, eez, edc; logic [7:0] ed;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cap[$], exp_q[$], pay_q[$];
  logic [15:0] desc_q[$];
  int nchk = 0, nfail = 0, nerr = 0, ntx = 0, exp_err = 0;

  function automatic vec_t mk(input logic pv, input logic [7:0] tg, input logic [7:0] sz,
                              input logic yv, input logic [7:0] yd, input logic cr,
                              input logic etx, input logic epr, input logic eyr, input logic ebz,
                              input logic eez, input logic edc, input logic [7:0] ed);
    vec_t v;
    v.pv = pv; v.tg = tg; v.sz = sz; v.yv = yv; v.yd = yd; v.cr = cr;
    v.etx = etx; v.epr = epr; v.eyr = eyr; v.ebz = ebz; v.eez = eez; v.edc = edc; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Samples the link at mid-cycle, recording every transferred flit.
  task automatic tick();
    @(negedge clock);
    if (!reset && tx) begin cap.push_back(data_out); ntx++; end
    if (!reset && err_zero) nerr++;
  endtask

  task automatic add_pkt(input logic [7:0] tg, input logic [7:0] sz);
    logic [7:0] d;
    desc_q.push_back({tg, sz});
    if (sz == 8'd0) exp_err++;
    else begin
      exp_q.push_back(tg); exp_q.push_back(sz);
      for (int k = 0; k < int'(sz); k++) begin
        d = 8'($urandom);
        exp_q.push_back(d); pay_q.push_back(d);
      end
    end
  endtask

  // mode 0: random valids and credit; mode 1: descriptor always valid, payload valid on alternate cycles, full credit.
  task automatic run_q(input int mode, input int max_cyc, input string nm);
    int  cyc = 0;
    logic done = 1'b0;
    cap.delete(); nerr = 0; ntx = 0;
    while (!done && cyc < max_cyc) begin
      step();
      pkt_valid = (desc_q.size() != 0) && (mode == 1 || $urandom_range(0, 3) != 0);
      if (desc_q.size() != 0) {pkt_target, pkt_size} = desc_q[0];
      pay_valid = (pay_q.size() != 0) && (mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0));
      if (pay_q.size() != 0) pay_data = pay_q[0];
      credit_i = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
      done = (desc_q.size() == 0) && (pay_q.size() == 0) && !busy;
      if (pkt_valid && pkt_ready) begin void'(desc_q.pop_front()); done = 1'b0; end
      if (pay_valid && pay_ready) begin void'(pay_q.pop_front()); done = 1'b0; end
      cyc++;
    end
    pkt_valid = 1'b0; pay_valid = 1'b0; credit_i = 1'b1;
    chk({nm, " completed"}, 32'(done), 32'd1);
    chk({nm, " flit count"}, cap.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap.size(); k++)
      chk($sformatf("%s flit %0d", nm, k), cap[k], exp_q[k]);
    chk({nm, " err_zero pulses"}, nerr, exp_err);
    exp_q.delete(); desc_q.delete(); pay_q.delete(); exp_err = 0;
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 0; pkt_target = 0; pkt_size = 0;
    pay_valid = 0; pay_data = 0; credit_i = 1;

    // single packet
    vecs.push_back(mk(1, 8'h11, 8'h03, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA1, 1, 1, 0, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA1, 1, 1, 0, 1, 1, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA2, 1, 1, 0, 1, 1, 0, 1, 8'hA1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA3, 1, 1, 0, 1, 1, 0, 1, 8'hA2));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0, 1, 0, 1, 8'hA3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    // credit stall with size flit held
    vecs.push_back(mk(1, 8'h11, 8'h03, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA1, 1, 1, 0, 0, 1, 0, 1, 8'h11));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA1, 0, 0, 0, 0, 1, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA1, 1, 1, 0, 1, 1, 0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA2, 1, 1, 0, 1, 1, 0, 1, 8'hA1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hA3, 1, 1, 0, 1, 1, 0, 1, 8'hA2));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0, 1, 0, 1, 8'hA3));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    // back-to-back packets
    vecs.push_back(mk(1, 8'h22, 8'h01, 1, 8'hB1, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h33, 8'h02, 1, 8'hB1, 1, 1, 0, 0, 1, 0, 1, 8'h22));
    vecs.push_back(mk(1, 8'h33, 8'h02, 1, 8'hB1, 1, 1, 0, 1, 1, 0, 1, 8'h01));
    vecs.push_back(mk(1, 8'h33, 8'h02, 1, 8'hC1, 1, 1, 1, 0, 1, 0, 1, 8'hB1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hC1, 1, 1, 0, 0, 1, 0, 1, 8'h33));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hC1, 1, 1, 0, 1, 1, 0, 1, 8'h02));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'hC2, 1, 1, 0, 1, 1, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0, 1, 0, 1, 8'hC2));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    // zero-size descriptor, then a normal one
    vecs.push_back(mk(1, 8'h44, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h55, 8'h01, 1, 8'h5A, 1, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h5A, 1, 1, 0, 0, 1, 0, 1, 8'h55));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h5A, 1, 1, 0, 1, 1, 0, 1, 8'h01));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 1, 0, 1, 0, 1, 8'h5A));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset tx", 32'(tx), 0);
    chk("reset pkt_ready", 32'(pkt_ready), 1);
    chk("reset pay_ready", 32'(pay_ready), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset err_zero", 32'(err_zero), 0);

    foreach (vecs[i]) begin
      step();
      pkt_valid = vecs[i].pv; pkt_target = vecs[i].tg; pkt_size = vecs[i].sz;
      pay_valid = vecs[i].yv; pay_data = vecs[i].yd; credit_i = vecs[i].cr;
      tick();
      chk($sformatf("v%0d tx", i), 32'(tx), 32'(vecs[i].etx));
      chk($sformatf("v%0d pkt_ready", i), 32'(pkt_ready), 32'(vecs[i].epr));
      chk($sformatf("v%0d pay_ready", i), 32'(pay_ready), 32'(vecs[i].eyr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].ebz));
      chk($sformatf("v%0d err_zero", i), 32'(err_zero), 32'(vecs[i].eez));
      if (vecs[i].edc) chk($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].ed));
    end

    // reset after the second payload flit of a size-5 packet has left
    step();
    pkt_valid = 1; pkt_target = 8'h66; pkt_size = 8'd5;
    pay_valid = 1; pay_data = 8'h61; credit_i = 1;
    cap.delete();
    tick();
    for (int k = 0; k < 20 && cap.size() < 4; k++) begin
      step();
      pkt_valid = 1'b0;
      tick();
      if (pay_ready) pay_data = pay_data + 8'd1;
    end
    chk("mid-packet flits before reset", cap.size(), 4);
    step();
    reset = 1'b1; pay_valid = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset tx", 32'(tx), 0);
    chk("post-reset busy", 32'(busy), 0);
    chk("post-reset pkt_ready", 32'(pkt_ready), 1);
    chk("post-reset pay_ready", 32'(pay_ready), 0);
    add_pkt(8'h77, 8'd2);
    run_q(0, 200, "fresh after reset");

    // payload gaps: pay_valid alternates
    add_pkt(8'h88, 8'd4);
    run_q(1, 100, "payload gaps");
    chk("payload gaps tx cycles", ntx, 6);

    // randomized traffic against the stream model
    for (int p = 0; p < 40; p++)
      add_pkt(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6)));
    run_q(0, 5000, "random");

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
